// File: rtl/mux8_rr_arbiter_pkg.sv
// mux8_rr_arbiter_pkg: shared constants, FSM state type and one-hot helper
package mux8_rr_arbiter_pkg;
   localparam int N_REQ = 8;
   localparam int SEL_W = 3;
   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_e;
   function automatic logic [SEL_W-1:0] oh2idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] r;
      r = '0;
      for (int i = 0; i < N_REQ; i++)
         if (oh[i]) r = r | SEL_W'(i);
      return r;
   endfunction
endpackage

// File: rtl/mux8_rr_arbiter_mux8.sv
// mux8: single-bit 8:1 multiplexer
module mux8
   import mux8_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] d_i,
   input  logic [SEL_W-1:0] s_i,
   output logic             y_o
);
   assign y_o = d_i[s_i];
endmodule

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// rr_pick8: first set request after ptr, wrapping 7->0
module rr_pick8
   import mux8_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic             found_o,
   output logic [SEL_W-1:0] idx_o
);
   // Scan farthest-first so the nearest candidate after ptr overwrites last.
   always_comb begin
      idx_o = '0;
      for (int k = N_REQ-1; k >= 0; k--)
         if (req_i[ptr_i + SEL_W'(k) + SEL_W'(1)]) idx_o = ptr_i + SEL_W'(k) + SEL_W'(1);
   end
   assign found_o = |req_i;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of a shared 8:1 single-bit channel
module mux8_rr_arbiter
   import mux8_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = $clog2(MAX_HOLD)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_i,
   input  logic [N_REQ-1:0] in_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             busy_o,
   output logic             y_o,
   output logic             timeout_o
);
   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, timeout_q, timeout_d;
   logic             found, to, arb, win, mux_y;
   rr_pick8 u_pick (.req_i(req_i), .ptr_i(ptr_q), .found_o(found), .idx_o(idx));
   mux8 u_mux (.d_i(in_i), .s_i(sel_q), .y_o(mux_y));
   // ptr_q always names the current owner, so one picker serves release and timeout.
   assign to  = (state_q == GRANT) & req_i[sel_q] & (cnt_q == CNT_W'(MAX_HOLD-1));
   assign arb = (state_q == IDLE) | ~req_i[sel_q] | to;
   assign win = arb & found;
   always_comb begin
      state_d   = win ? GRANT : arb ? IDLE : state_q;
      gnt_d     = win ? N_REQ'(1) << idx : arb ? '0 : gnt_q;
      sel_d     = win ? oh2idx(gnt_d) : sel_q;
      busy_d    = win | (~arb & busy_q);
      cnt_d     = arb ? '0 : cnt_q + CNT_W'(1);
      ptr_d     = win ? idx : ptr_q;
      timeout_d = to;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         ptr_q     <= SEL_W'(N_REQ-1);
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         timeout_q <= timeout_d;
      end
   end
   assign gnt_o     = gnt_q;
   assign sel_o     = sel_q;
   assign busy_o    = busy_q;
   assign timeout_o = timeout_q;
   assign y_o       = busy_q & mux_y;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: scoreboard bench against a behavioural round-robin model
module tb_mux8_rr_arbiter;
   localparam int MH = 4;
   typedef struct {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       busy;
      logic       to;
      logic       y;
   } exp_t;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [7:0] req_i = 8'hFF, in_i = 8'h00, gnt_o;
   logic [2:0] sel_o;
   logic       busy_o, y_o, timeout_o;
   int         n_checks = 0, n_errors = 0;
   exp_t       sb[$];
   bit         m_busy;
   int         m_sel, m_ptr, m_cnt;
   bit         m_to;
   mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .in_i(in_i),
      .gnt_o(gnt_o), .sel_o(sel_o), .busy_o(busy_o), .y_o(y_o), .timeout_o(timeout_o)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask
   task automatic model_reset();
      m_busy = 0; m_sel = 0; m_ptr = 7; m_cnt = 0; m_to = 0;
   endtask
   // One cycle: drive at negedge, predict, push; compare after the posedge.
   task automatic step(input logic [7:0] r, input logic [7:0] d);
      exp_t e, o;
      bit   found;
      req_i = r;
      in_i  = d;
      if (!m_busy || !r[m_sel] || m_cnt == MH-1) begin
         m_to  = m_busy && r[m_sel] && m_cnt == MH-1;
         found = 0;
         for (int k = 1; k <= 8 && !found; k++)
            if (r[(m_ptr + k) % 8]) begin
               found = 1; m_sel = (m_ptr + k) % 8; m_ptr = m_sel;
            end
         m_busy = found;
         m_cnt  = 0;
      end else begin
         m_to = 0;
         m_cnt++;
      end
      e.gnt  = m_busy ? 8'(1) << m_sel : 8'h00;
      e.sel  = 3'(m_sel);
      e.busy = m_busy;
      e.to   = m_to;
      e.y    = m_busy ? d[m_sel] : 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      check("gnt", 32'(gnt_o), 32'(o.gnt));
      check("sel", 32'(sel_o), 32'(o.sel));
      check("busy", 32'(busy_o), 32'(o.busy));
      check("timeout", 32'(timeout_o), 32'(o.to));
      check("y", 32'(y_o), 32'(o.y));
      @(negedge clk);
   endtask
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_gnt", 32'(gnt_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      check("rst_y", 32'(y_o), 32'h0);
      check("rst_timeout", 32'(timeout_o), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      model_reset();
      in_i = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      check("reset_gnt", 32'(gnt_o), 32'h0);
      check("reset_busy", 32'(busy_o), 32'h0);
      check("reset_y", 32'(y_o), 32'h0);
      check("reset_sel", 32'(sel_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(8'hFF, 8'h00);
      check("first_gnt", 32'(gnt_o), 32'h01);
      // Rotation through all eight plus wrap to 0.
      repeat (36) step(8'hFF, 8'(($urandom)));
      async_reset();
      // Back-to-back handover 2 -> 5.
      repeat (3) step(8'h24, 8'h24);
      step(8'h20, 8'h20);
      check("b2b_gnt", 32'(gnt_o), 32'h20);
      check("b2b_sel", 32'(sel_o), 32'h5);
      check("b2b_busy", 32'(busy_o), 32'h1);
      check("b2b_to", 32'(timeout_o), 32'h0);
      step(8'h00, 8'h00);
      // Sole owner keeps being re-granted.
      repeat (12) step(8'h08, 8'h08);
      step(8'h00, 8'h00);
      // Datapath on requester 6, then idle forces y low.
      for (int i = 0; i < 10; i++) step(8'h40, (i % 2) ? 8'h40 : 8'hBF);
      step(8'h00, 8'hFF);
      check("idle_y", 32'(y_o), 32'h0);
      // Reset mid-grant of requester 4, then requester 0 wins first.
      repeat (2) step(8'h10, 8'hFF);
      check("pre_rst_gnt", 32'(gnt_o), 32'h10);
      async_reset();
      step(8'h11, 8'h01);
      check("post_rst_gnt", 32'(gnt_o), 32'h01);
      // Random traffic with sticky-ish requests.
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 8'($urandom));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
